npu_apb_master: RTL and testbench
=================================

# npu_apb_master

Single-outstanding APB requester that turns a valid/ready command stream from NPU control logic (sequencer, debug port) into APB transfers. It drives the `APB_BUS_SV.Master` modport and returns read data and error status on a valid/ready response channel. It adds a local alignment check and a bus-hang timeout so a dead slave cannot stall the NPU control path.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 256: maximum ACCESS-phase cycles without `p_ready` before the transfer is aborted; 0 disables the timeout.
- Widths `APB_A_W` and `APB_D_W` come from `npu_pkg`.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  synchronous active-low reset
- `req_valid`  in  1  command valid
- `req_ready`  out  1  command accepted when `req_valid & req_ready`
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  `APB_A_W`  byte address
- `req_wdata`  in  `APB_D_W`  write data
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready`
- `rsp_rdata`  out  `APB_D_W`  read data; 0 for writes and errors
- `rsp_err`  out  1  slave error, alignment error, or timeout
- `rsp_timeout`  out  1  error cause is timeout
- `apb`  `APB_BUS_SV.Master`  drives `p_addr`, `p_sel`, `p_enable`, `p_write`, `p_wdata`; samples `p_ready`, `p_rdata`, `p_slverr`

## Operation
- FSM states are IDLE, SETUP, ACCESS and RESP.
- **IDLE**
  - `req_ready` = 1.
  - On handshake, latch write, address and wdata into the `p_*` registers.
  - If `req_addr[1:0] != 0`: go to RESP with `rsp_err` = 1 and `rsp_timeout` = 0. No bus cycle is issued.
  - Otherwise go to SETUP.
- **SETUP**
  - `p_sel` = 1, `p_enable` = 0, for exactly one cycle, then go to ACCESS.
- **ACCESS**
  - `p_sel` = 1, `p_enable` = 1.
  - If `p_ready` = 1: capture `rsp_rdata` = `p_rdata` for a read (0 for a write) and `rsp_err` = `p_slverr`, then go to RESP. On `p_slverr` = 1, `rsp_rdata` is forced to 0.
  - Otherwise increment the wait counter. If the counter equals `TIMEOUT_CYC` − 1 (and `TIMEOUT_CYC` ≠ 0), go to RESP with `rsp_err` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0.
  - The wait counter is `$clog2(TIMEOUT_CYC+1)` bits wide and clears on entry to SETUP.
- **RESP**
  - `rsp_valid` = 1 and `req_ready` = 0.
  - Response fields hold stable until `rsp_ready`, then go to IDLE.
- `p_addr`, `p_write` and `p_wdata` are stable from SETUP through the end of ACCESS. They keep their last value in IDLE and RESP.
- Only one transaction is outstanding at a time; no new command is accepted until the response is consumed.

## Timing
- Reset values:
  - State = IDLE, `req_ready` = 1.
  - `rsp_valid`, `rsp_err`, `rsp_timeout` = 0; `rsp_rdata` = 0.
  - `p_sel`, `p_enable`, `p_write` = 0; `p_addr` = 0, `p_wdata` = 0.
- Handshake at edge E0. SETUP occupies cycle E0→E1 and ACCESS starts at E1.
  - With zero-wait `p_ready`, `rsp_valid` is high from E2. Minimum command-to-response latency is 2 cycles.
  - Each slave wait cycle adds 1 cycle.
- Alignment error: `rsp_valid` high the cycle after the handshake.
- Timeout with `TIMEOUT_CYC` = T: `p_sel`/`p_enable` drop and `rsp_valid` rises after T ACCESS cycles with `p_ready` low.
  - If `p_ready` = 1 in the T-th cycle, the transfer completes normally (ready wins over timeout).
- `rsp_ready` may be held high in advance: RESP then lasts exactly 1 cycle, and the next command is accepted the cycle after that.
- The earliest back-to-back transfer has 1 IDLE cycle between the two APB transfers.
- Reset asserted mid-transfer: at the next edge all outputs take their reset values, the transfer is abandoned, and no response is produced.
- All outputs are registered; there is no combinational path from `p_ready` or `rsp_ready` to outputs.

## Test plan
- Write 0x0000_0010 ← 0xDEAD_BEEF with a zero-wait slave.
  - SETUP then ACCESS, one cycle each, with `p_write` = 1 and `p_wdata` = 0xDEADBEEF.
  - `rsp_valid` 2 cycles after the handshake, `rsp_err` = 0, `rsp_rdata` = 0.
- Read 0x0000_0020 with a slave returning 0x1234_5678 after 3 wait cycles.
  - `p_addr` and `p_enable` stable for 4 ACCESS cycles.
  - `rsp_rdata` = 0x12345678, response 5 cycles after the handshake.
- Read with `p_slverr` = 1 on the ready cycle: `rsp_err` = 1, `rsp_timeout` = 0, `rsp_rdata` = 0.
- Request to address 0x0000_0013: no `p_sel` pulse; `rsp_valid` the next cycle with `rsp_err` = 1.
- `TIMEOUT_CYC` = 4 with a slave that never asserts ready.
  - Exactly 4 ACCESS cycles, then `p_sel` = 0 and `rsp_err` = `rsp_timeout` = 1.
  - Repeat with ready arriving in the 4th cycle: normal completion.
- `rsp_ready` held low for 10 cycles: response fields stable and `req_ready` = 0. Assert `rst_n` low during ACCESS: next cycle `p_sel` = 0, `rsp_valid` = 0, `req_ready` = 1.

Source files
------------

// File: rtl/npu_apb_master.sv
// Single-outstanding APB requester: valid/ready command in, APB transfer out,
// valid/ready response back, with local alignment check and bus-hang timeout.

package npu_pkg;
  localparam int unsigned APB_A_W = 32;
  localparam int unsigned APB_D_W = 32;
endpackage

interface APB_BUS_SV;
  logic [npu_pkg::APB_A_W-1:0] p_addr;
  logic                        p_sel;
  logic                        p_enable;
  logic                        p_write;
  logic [npu_pkg::APB_D_W-1:0] p_wdata;
  logic                        p_ready;
  logic [npu_pkg::APB_D_W-1:0] p_rdata;
  logic                        p_slverr;

  modport Master (
    output p_addr, p_sel, p_enable, p_write, p_wdata,
    input  p_ready, p_rdata, p_slverr
  );
  modport Slave (
    input  p_addr, p_sel, p_enable, p_write, p_wdata,
    output p_ready, p_rdata, p_slverr
  );
endinterface

module npu_apb_master
  import npu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [APB_A_W-1:0] req_addr,
  input  logic [APB_D_W-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [APB_D_W-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               rsp_timeout,
  APB_BUS_SV.Master          apb
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // A zero timeout still needs a 1-bit counter to keep the declaration legal.
  localparam int unsigned CW      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      rsp_timeout  <= 1'b0;
      apb.p_addr   <= '0;
      apb.p_sel    <= 1'b0;
      apb.p_enable <= 1'b0;
      apb.p_write  <= 1'b0;
      apb.p_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            apb.p_write <= req_write;
            apb.p_addr  <= req_addr;
            apb.p_wdata <= req_wdata;
            req_ready   <= 1'b0;
            if (req_addr[1:0] != 2'b00) begin
              state       <= S_RESP;
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= '0;
            end else begin
              state     <= S_SETUP;
              apb.p_sel <= 1'b1;
              wait_cnt  <= '0;
            end
          end
        end
        S_SETUP: begin
          apb.p_enable <= 1'b1;
          state        <= S_ACCESS;
        end
        S_ACCESS: begin
          if (apb.p_ready) begin
            apb.p_sel    <= 1'b0;
            apb.p_enable <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_err      <= apb.p_slverr;
            rsp_timeout  <= 1'b0;
            rsp_rdata    <= (!apb.p_write && !apb.p_slverr) ? apb.p_rdata : '0;
            state        <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (TIMEOUT_CYC != 0 && wait_cnt == CW'(TO_LAST)) begin
              apb.p_sel    <= 1'b0;
              apb.p_enable <= 1'b0;
              rsp_valid    <= 1'b1;
              rsp_err      <= 1'b1;
              rsp_timeout  <= 1'b1;
              rsp_rdata    <= '0;
              state        <= S_RESP;
            end
          end
        end
        default: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npu_apb_master.sv
// Directed bench for npu_apb_master with a behavioural APB slave (TIMEOUT_CYC = 4).

module tb_npu_apb_master;
  import npu_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [APB_A_W-1:0] req_addr;
  logic [APB_D_W-1:0] req_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [APB_D_W-1:0] rsp_rdata;
  logic               rsp_err;
  logic               rsp_timeout;

  APB_BUS_SV apb ();

  npu_apb_master #(.TIMEOUT_CYC(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .apb         (apb)
  );

  always #5 clk = ~clk;

  // Slave: ready after wait_n wait cycles, unless never_ready is set.
  int          wait_n      = 0;
  logic        never_ready = 1'b0;
  logic        slv_err     = 1'b0;
  logic [31:0] rd_val      = '0;
  int          wcnt        = 0;

  always @(negedge clk) begin
    if (apb.p_sel && apb.p_enable && !never_ready) begin
      apb.p_ready = (wcnt == wait_n);
      wcnt++;
    end else begin
      apb.p_ready = 1'b0;
      wcnt = 0;
    end
    apb.p_slverr = apb.p_ready & slv_err;
    apb.p_rdata  = rd_val;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one edge; returns 1 ns after the handshake edge.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    tick();
    req_valid = 1'b0;
  endtask

  logic [31:0] held;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    chkb("rst_req_ready", req_ready, 1'b1);
    chkb("rst_rsp_valid", rsp_valid, 1'b0);
    chkb("rst_rsp_err", rsp_err, 1'b0);
    chkb("rst_p_sel", apb.p_sel, 1'b0);
    chk ("rst_p_addr", apb.p_addr, 32'h0);
    chk ("rst_rsp_rdata", rsp_rdata, 32'h0);

    // Zero-wait write
    wait_n = 0; rd_val = 32'hA5A5_A5A5;
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    chkb("wr_setup_sel", apb.p_sel, 1'b1);
    chkb("wr_setup_en", apb.p_enable, 1'b0);
    chkb("wr_p_write", apb.p_write, 1'b1);
    chk ("wr_p_wdata", apb.p_wdata, 32'hDEAD_BEEF);
    chk ("wr_p_addr", apb.p_addr, 32'h0000_0010);
    chkb("wr_req_ready_busy", req_ready, 1'b0);
    tick();
    chkb("wr_access_en", apb.p_enable, 1'b1);
    chkb("wr_access_valid", rsp_valid, 1'b0);
    tick();
    chkb("wr_rsp_valid", rsp_valid, 1'b1);
    chkb("wr_rsp_err", rsp_err, 1'b0);
    chk ("wr_rsp_rdata", rsp_rdata, 32'h0);
    chkb("wr_sel_drop", apb.p_sel, 1'b0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chkb("wr_rsp_done", rsp_valid, 1'b0);
    chkb("wr_idle_ready", req_ready, 1'b1);

    // Read with 3 wait cycles, then a 10-cycle stalled response
    wait_n = 3; rd_val = 32'h1234_5678;
    issue(1'b0, 32'h0000_0020, 32'h0);
    chkb("rd_p_write", apb.p_write, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chkb("rd_access_en", apb.p_enable, 1'b1);
      chk ("rd_access_addr", apb.p_addr, 32'h0000_0020);
      chkb("rd_access_novalid", rsp_valid, 1'b0);
      tick();
    end
    chkb("rd_rsp_valid", rsp_valid, 1'b1);
    chk ("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    chkb("rd_rsp_err", rsp_err, 1'b0);
    held = rsp_rdata;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      chkb("hold_valid", rsp_valid, 1'b1);
      chk ("hold_rdata", rsp_rdata, held);
      chkb("hold_req_ready", req_ready, 1'b0);
      chkb("hold_no_sel", apb.p_sel, 1'b0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chkb("rd_rsp_done", rsp_valid, 1'b0);

    // Slave error, rsp_ready held high in advance
    wait_n = 0; slv_err = 1'b1; rd_val = 32'hCAFE_F00D;
    issue(1'b0, 32'h0000_0030, 32'h0);
    tick();
    tick();
    chkb("slverr_valid", rsp_valid, 1'b1);
    chkb("slverr_err", rsp_err, 1'b1);
    chkb("slverr_timeout", rsp_timeout, 1'b0);
    chk ("slverr_rdata", rsp_rdata, 32'h0);
    tick();
    chkb("slverr_done", rsp_valid, 1'b0);
    chkb("slverr_idle_ready", req_ready, 1'b1);
    slv_err = 1'b0;

    // Misaligned address: no bus cycle
    issue(1'b0, 32'h0000_0013, 32'h0);
    chkb("misal_valid", rsp_valid, 1'b1);
    chkb("misal_err", rsp_err, 1'b1);
    chkb("misal_timeout", rsp_timeout, 1'b0);
    chkb("misal_no_sel", apb.p_sel, 1'b0);
    chk ("misal_addr_latched", apb.p_addr, 32'h0000_0013);
    tick();
    chkb("misal_done", rsp_valid, 1'b0);
    rsp_ready = 1'b0;

    // Timeout: slave never ready, TIMEOUT_CYC = 4
    never_ready = 1'b1; rd_val = 32'h7777_7777;
    issue(1'b0, 32'h0000_0040, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chkb("to_access_sel", apb.p_sel, 1'b1);
      chkb("to_access_novalid", rsp_valid, 1'b0);
      tick();
    end
    chkb("to_sel_drop", apb.p_sel, 1'b0);
    chkb("to_en_drop", apb.p_enable, 1'b0);
    chkb("to_valid", rsp_valid, 1'b1);
    chkb("to_err", rsp_err, 1'b1);
    chkb("to_timeout", rsp_timeout, 1'b1);
    chk ("to_rdata", rsp_rdata, 32'h0);
    rsp_ready = 1'b1;
    tick();
    never_ready = 1'b0;

    // Ready in the 4th ACCESS cycle wins over timeout (write: rdata 0)
    wait_n = 3;
    issue(1'b1, 32'h0000_0044, 32'h0000_55AA);
    rsp_ready = 1'b0;
    repeat (5) tick();
    chkb("late_valid", rsp_valid, 1'b1);
    chkb("late_err", rsp_err, 1'b0);
    chkb("late_timeout", rsp_timeout, 1'b0);
    chk ("late_rdata", rsp_rdata, 32'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset during ACCESS
    wait_n = 8;
    issue(1'b1, 32'h0000_0050, 32'h1111_2222);
    tick();
    chkb("mid_access_en", apb.p_enable, 1'b1);
    rst_n = 1'b0;
    tick();
    chkb("mid_rst_sel", apb.p_sel, 1'b0);
    chkb("mid_rst_en", apb.p_enable, 1'b0);
    chkb("mid_rst_valid", rsp_valid, 1'b0);
    chkb("mid_rst_req_ready", req_ready, 1'b1);
    chk ("mid_rst_addr", apb.p_addr, 32'h0);
    rst_n = 1'b1;
    repeat (3) tick();
    chkb("mid_rst_no_rsp", rsp_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
